// File: rtl/ternary_matvec_stream.sv
// Streaming ternary matrix-vector product: LANES activations per beat, all N_OUT
// rows accumulate in parallel, and the result vector is held until it is consumed.
module tmv_row #(
  parameter int IN_W  = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 12
) (
  input  logic [LANES-1:0][IN_W-1:0] x,
  input  logic [LANES-1:0][1:0]      w,
  output logic [ACC_W-1:0]           sum,
  output logic                       bad
);
  logic [ACC_W-1:0] xe;

  // Sign-extend before negating so that -(-2^(IN_W-1)) stays exact at ACC_W.
  always_comb begin
    sum = '0;
    bad = 1'b0;
    xe  = '0;
    for (int k = 0; k < LANES; k++) begin
      xe = {{(ACC_W-IN_W){x[k][IN_W-1]}}, x[k]};
      case (w[k])
        2'b01:   sum = sum + xe;
        2'b11:   sum = sum - xe;
        2'b10:   bad = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module ternary_matvec_stream #(
  parameter int IN_W  = 8,
  parameter int N_IN  = 64,
  parameter int N_OUT = 16,
  parameter int LANES = 4,
  parameter int RELU  = 0,
  parameter int ACC_W = IN_W + $clog2(N_IN) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*IN_W-1:0]    in_data,
  input  logic [N_OUT*LANES*2-1:0] w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT*ACC_W-1:0]   out_data,
  output logic                     w_err
);
  localparam int BEATS = N_IN / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state_q, state_d;

  logic [LANES-1:0][IN_W-1:0]        x_vec;
  logic [N_OUT-1:0][LANES-1:0][1:0]  w_vec;
  logic [N_OUT-1:0][ACC_W-1:0]       beat_sum, nxt, acc, res_q;
  logic [N_OUT-1:0]                  row_bad;
  logic [CNT_W-1:0]                  beat_cnt;
  logic                              accept, last;

  assign x_vec    = in_data;
  assign w_vec    = w_data;
  assign out_data = res_q;
  assign accept   = in_valid && in_ready;
  assign last     = (beat_cnt == CNT_W'(BEATS-1));

  for (genvar r = 0; r < N_OUT; r++) begin : g_row
    tmv_row #(.IN_W(IN_W), .LANES(LANES), .ACC_W(ACC_W)) u_row (
      .x(x_vec), .w(w_vec[r]), .sum(beat_sum[r]), .bad(row_bad[r])
    );
  end

  // First beat loads the accumulator directly, so no clear cycle is needed.
  always_comb begin
    nxt = '0;
    for (int r = 0; r < N_OUT; r++)
      nxt[r] = ((beat_cnt == '0) ? '0 : acc[r]) + beat_sum[r];
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACCUM;
      beat_cnt <= '0;
      acc      <= '0;
      res_q    <= '0;
      w_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc <= nxt;
        if (|row_bad) w_err <= 1'b1;
        if (last) begin
          beat_cnt <= '0;
          for (int r = 0; r < N_OUT; r++)
            res_q[r] <= (RELU != 0 && nxt[r][ACC_W-1]) ? '0 : nxt[r];
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ternary_matvec_stream.sv
// Directed bench: a raw (RELU=0) and a clamped (RELU=1) instance share all
// stimulus; row sums are hand-computed for N_IN=8, LANES=4, N_OUT=4.
module tb_ternary_matvec_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] w_data = '0;
  logic        in_ready0, out_valid0, w_err0;
  logic        in_ready1, out_valid1, w_err1;
  logic [47:0] out_data0, out_data1;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ternary_matvec_stream #(.IN_W(8), .N_IN(8), .N_OUT(4), .LANES(4), .RELU(0), .ACC_W(12)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .w_data(w_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .w_err(w_err0));

  ternary_matvec_stream #(.IN_W(8), .N_IN(8), .N_OUT(4), .LANES(4), .RELU(1), .ACC_W(12)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .w_data(w_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .w_err(w_err1));

  // Row words are {lane3,lane2,lane1,lane0}; codes 01=+1, 11=-1, 00=0, 10=reserved.
  localparam logic [7:0] RP = 8'h55, RM = 8'hFF, RZ = 8'h00, RALT = 8'hDD, RBAD = 8'h56;

  function automatic int rowv(input logic [47:0] d, input int r);
    logic [11:0] t;
    t = d[r*12 +: 12];
    return int'($signed(t));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input int rdy, input int vld, input int err);
    chk({tag, " in_ready"},  int'(in_ready0),  rdy);
    chk({tag, " out_valid"}, int'(out_valid0), vld);
    chk({tag, " w_err"},     int'(w_err0),     err);
    chk({tag, " relu out_valid"}, int'(out_valid1), vld);
  endtask

  task automatic chk_rows(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("%s row%0d", tag, r), rowv(out_data0, r), e[r]);
      chk($sformatf("%s relu row%0d", tag, r), rowv(out_data1, r), (e[r] < 0) ? 0 : e[r]);
    end
  endtask

  task automatic beat(input logic [31:0] x, input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = x;
    w_data   = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(2);
    rst = 1'b0;
    chk_ctl("reset", 1, 0, 0);
    chk_rows("reset", 0, 0, 0, 0);

    // x=1: rows {+1, -1, 0, alternating}; idle gaps between beats must hold state
    beat(32'h01010101, {RALT, RZ, RM, RP});
    chk_ctl("v1 beat1", 1, 0, 0);
    idle(2);
    chk_ctl("v1 idle", 1, 0, 0);
    beat(32'h01010101, {RALT, RZ, RM, RP});
    chk_ctl("v1 done", 0, 1, 0);
    chk_rows("v1", 8, -8, 0, 0);
    consume();
    chk_ctl("v1 consumed", 1, 0, 0);

    // x=-128: negation of the most negative activation must not wrap
    beat(32'h80808080, {RZ, RZ, RP, RM});
    beat(32'h80808080, {RZ, RZ, RP, RM});
    chk_ctl("v2 done", 0, 1, 0);
    chk_rows("v2", 1024, -1024, 0, 0);

    // Backpressure: producer offers a beat while result is held
    in_valid = 1'b1;
    in_data  = 32'h01010101;
    w_data   = {RALT, RZ, RM, RP};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_ctl($sformatf("hold%0d", i), 0, 1, 0);
      chk($sformatf("hold%0d row0", i), rowv(out_data0, 0), 1024);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_ctl("v2 consumed", 1, 0, 0);
    @(posedge clk); #1;
    chk_ctl("v3 beat1", 1, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_ctl("v3 done", 0, 1, 0);
    chk_rows("v3", 8, -8, 0, 0);
    consume();

    // Reset mid-vector discards the partial sum
    beat(32'h05050505, {RP, RP, RP, RP});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_ctl("midrst", 1, 0, 0);
    chk_rows("midrst", 0, 0, 0, 0);
    beat(32'h02020202, {RZ, RZ, RZ, RP});
    chk_ctl("v4 beat1", 1, 0, 0);
    beat(32'h02020202, {RZ, RZ, RZ, RP});
    chk_ctl("v4 done", 0, 1, 0);
    chk_rows("v4", 16, 0, 0, 0);
    consume();

    // Reserved code contributes 0 and latches w_err
    beat(32'h01010101, {RZ, RZ, RZ, RBAD});
    chk_ctl("v5 beat1", 1, 0, 1);
    beat(32'h01010101, {RZ, RZ, RZ, RP});
    chk_ctl("v5 done", 0, 1, 1);
    chk_rows("v5", 7, 0, 0, 0);
    consume();
    beat(32'h01010101, {RALT, RZ, RM, RP});
    beat(32'h01010101, {RALT, RZ, RM, RP});
    chk_ctl("v6 done", 0, 1, 1);
    chk_rows("v6", 8, -8, 0, 0);

    // Reset in HOLD drops the pending result and clears w_err
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_ctl("holdrst", 1, 0, 0);
    chk_rows("holdrst", 0, 0, 0, 0);
    idle(2);
    chk_ctl("holdrst idle", 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ternary_matvec_stream.md
TERNARY_MATVEC_STREAM -- requirements
Module: ternary_matvec_stream

Interface
REQ-001 Parameter IN_W, default 8: signed activation width.
REQ-002 Parameter N_IN, default 64: vector length; SHALL be a multiple of LANES.
REQ-003 Parameter N_OUT, default 16: output rows (matrix rows).
REQ-004 Parameter LANES, default 4: activations per input beat; BEATS = N_IN/LANES.
REQ-005 Parameter RELU, default 0: 1 = clamp negative outputs to 0.
REQ-006 Parameter ACC_W, default IN_W+$clog2(N_IN)+1: signed accumulator/output width.
REQ-007 clk  in  1  rising-edge clock; single clock domain.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 in_valid  in  1  input beat valid.
REQ-010 in_ready  out  1  block accepts a beat this cycle.
REQ-011 in_data  in  LANES*IN_W  signed activations; lane k at bits [k*IN_W +: IN_W].
REQ-012 w_data  in  N_OUT*LANES*2  ternary weights; row r, lane k at [(r*LANES+k)*2 +: 2]; sampled with in_data.
REQ-013 out_valid  out  1  result vector valid.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 out_data  out  N_OUT*ACC_W  signed row sums; row r at [r*ACC_W +: ACC_W].
REQ-016 w_err  out  1  sticky: a reserved weight code was accepted.

Function
REQ-017 Beat accepted iff in_valid && in_ready on a rising clk edge.
REQ-018 Weight code: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0; 2'b10 reserved, contributes 0 and sets w_err.
REQ-019 Activations sign-extended to ACC_W before negation; -(-2^(IN_W-1)) SHALL yield +2^(IN_W-1) exactly (no IN_W wrap).
REQ-020 FSM states: ACCUM, HOLD. ACCUM: in_ready=1, out_valid=0. HOLD: in_ready=0, out_valid=1.
REQ-021 In ACCUM, each accepted beat: acc[r] <= acc[r] + sum over k of w(r,k)*x(k), all N_OUT rows in the same cycle; beat_cnt increments.
REQ-022 First beat of a vector (beat_cnt==0) SHALL load acc[r] with the beat sum (no prior clear cycle needed).
REQ-023 On acceptance of beat BEATS-1: beat_cnt <= 0, out_data registered from final sums, FSM -> HOLD; out_valid high the next cycle (latency 1 cycle after last beat).
REQ-024 RELU=1: negative row results output as 0; RELU=0: raw signed sum.
REQ-025 HOLD: out_data and out_valid stable until out_valid && out_ready; then FSM -> ACCUM next cycle.
REQ-026 in_valid in HOLD ignored (in_ready=0); no beat lost, producer stalls.
REQ-027 Throughput: one vector per BEATS+1 cycles with no backpressure.
REQ-028 in_valid low in ACCUM: accumulators and beat_cnt hold.
REQ-029 ACC_W at default covers |sum| <= N_IN*2^(IN_W-1); no saturation or overflow logic required.
REQ-030 w_err cleared only by rst.

Reset
REQ-031 rst high at a clock edge: FSM -> ACCUM, beat_cnt=0, all acc=0, out_data=0, out_valid=0, w_err=0; in_ready=1 from the first cycle after rst deasserts.
REQ-032 rst mid-vector or in HOLD discards partial sums and pending result; no out_valid pulse results.
REQ-033 rst has priority over any simultaneous handshake.

Verification (N_IN=8, LANES=4, N_OUT=4, IN_W=8, ACC_W=12, BEATS=2)
REQ-034 All x=1, row0 all +1, row1 all -1, row2 all 0, row3 alternating +1/-1 -> out rows {8,-8,0,0}, out_valid one cycle after beat 2.
REQ-035 All x=-128, row0 all -1, row1 all +1 -> row0=+1024, row1=-1024 exact.
REQ-036 out_ready held low 5 cycles in HOLD with in_valid high -> in_ready=0, out_data stable, next vector starts only after the handshake.
REQ-037 rst asserted after beat 1; then a full vector of x=2 with row0 all +1 -> row0=16 (no stale partial sum).
REQ-038 Beat containing weight code 2'b10 -> contributes 0, w_err=1 and stays 1 across later vectors until rst.
REQ-039 RELU=1 rerun of REQ-034 -> rows {8,0,0,0}.
